// File: rtl/sd_in_pio_if.sv
// Avalon-MM slave bus bundle for the SD input PIO: register select, write strobe and data,
// plus the registered read-data return path.
interface sd_in_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/sd_in_pio.sv
// SD-side input PIO: synchronizes external lines and exposes them as DATA.
// Latches selected edges into a W1C capture register that drives a maskable irq.
module sd_in_pio #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  sd_in_pio_if.slave       bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned CntMax = SYNC_STAGES + 1;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] CntSat = CntW'(CntMax);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] delay_q, delay_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] sync_out, rise, fall, edge_sel, wdata;
  logic             capture_en, wr, wr_mask, wr_ecap;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sync_out = sync_q[SYNC_STAGES-1];
    delay_d  = sync_out;

    rise = sync_out & ~delay_q;
    fall = ~sync_out & delay_q;
    case (EDGE_TYPE)
      0:       edge_sel = rise;
      1:       edge_sel = fall;
      default: edge_sel = rise | fall;
    endcase

    // Captures stay off until the synchronizer and delay reg hold real samples, so lines
    // already high at reset release are not seen as edges.
    capture_en = (cnt_q == CntSat);
    cnt_d      = capture_en ? cnt_q : cnt_q + 1'b1;

    wr      = bus.chipselect & ~bus.write_n;
    wr_mask = wr && (bus.address == 2'd2);
    wr_ecap = wr && (bus.address == 2'd3);
    wdata   = bus.writedata[WIDTH-1:0];

    // A new edge wins over a same-cycle clear.
    ecap_d    = (capture_en ? edge_sel : '0) | (ecap_q & ~(wr_ecap ? wdata : '0));
    irqmask_d = wr_mask ? wdata : irqmask_q;

    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d[WIDTH-1:0] = sync_out;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = ecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      delay_q    <= '0;
      irqmask_q  <= '0;
      ecap_q     <= '0;
      readdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      delay_q    <= delay_d;
      irqmask_q  <= irqmask_d;
      ecap_q     <= ecap_d;
      readdata_q <= readdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(ecap_q & irqmask_q);

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_sd_in_pio.sv
// Bench for sd_in_pio: rising, falling and any-edge instances share stimulus and are compared
// each cycle against a sample-history reference model, plus directed scenario checks.
module tb_sd_in_pio;
  localparam int unsigned W  = 4;
  localparam int unsigned SS = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic [1:0]   addr = '0;
  logic         cs = 1'b0;
  logic         wn = 1'b1;
  logic [31:0]  wd = '0;
  logic         irq_obs [3];
  logic [31:0]  rd_obs  [3];

  int checks = 0;
  int errors = 0;

  sd_in_pio_if bus0 ();
  sd_in_pio_if bus1 ();
  sd_in_pio_if bus2 ();

  assign bus0.address = addr;  assign bus0.chipselect = cs;
  assign bus0.write_n = wn;    assign bus0.writedata  = wd;
  assign bus1.address = addr;  assign bus1.chipselect = cs;
  assign bus1.write_n = wn;    assign bus1.writedata  = wd;
  assign bus2.address = addr;  assign bus2.chipselect = cs;
  assign bus2.write_n = wn;    assign bus2.writedata  = wd;
  assign rd_obs[0] = bus0.readdata;
  assign rd_obs[1] = bus1.readdata;
  assign rd_obs[2] = bus2.readdata;

  sd_in_pio #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(SS)) u_dut_rise (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(in_port), .irq(irq_obs[0])
  );
  sd_in_pio #(.WIDTH(W), .EDGE_TYPE(1), .SYNC_STAGES(SS)) u_dut_fall (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .in_port(in_port), .irq(irq_obs[1])
  );
  sd_in_pio #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(SS)) u_dut_any (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port(in_port), .irq(irq_obs[2])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: DATA is the input as sampled SS clocks ago; edges compare consecutive
  // DATA values; captures count only from the (SS+2)th clock after reset release.
  logic [W-1:0] hist [$];
  logic [W-1:0] m_data, m_prev;
  logic [W-1:0] m_ecap [3];
  logic [W-1:0] m_mask [3];
  logic [31:0]  m_rd   [3];
  int           m_clks;

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < int'(SS); i++) hist.push_back('0);
    m_data = '0;
    m_prev = '0;
    m_clks = 0;
    for (int t = 0; t < 3; t++) begin
      m_ecap[t] = '0;
      m_mask[t] = '0;
      m_rd[t]   = '0;
    end
  endfunction

  function automatic void model_step();
    logic [W-1:0] edges [3];
    logic [W-1:0] clr;
    bit           en;
    bit           wr;
    edges[0] = m_data & ~m_prev;
    edges[1] = ~m_data & m_prev;
    edges[2] = m_data ^ m_prev;
    en  = (m_clks >= int'(SS) + 1);
    wr  = cs && !wn;
    clr = (wr && addr == 2'd3) ? wd[W-1:0] : '0;
    for (int t = 0; t < 3; t++) begin
      case (addr)
        2'd0:    m_rd[t] = 32'(m_data);
        2'd2:    m_rd[t] = 32'(m_mask[t]);
        2'd3:    m_rd[t] = 32'(m_ecap[t]);
        default: m_rd[t] = 32'h0;
      endcase
      m_ecap[t] = (m_ecap[t] & ~clr) | (en ? edges[t] : '0);
      if (wr && addr == 2'd2) m_mask[t] = wd[W-1:0];
    end
    hist.push_front(in_port);
    void'(hist.pop_back());
    m_prev = m_data;
    m_data = hist[SS-1];
    if (m_clks < 1000) m_clks++;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int t = 0; t < 3; t++) begin
      check($sformatf("rd%0d", t), rd_obs[t], m_rd[t]);
      check($sformatf("irq%0d", t), 32'(irq_obs[t]), 32'(|(m_ecap[t] & m_mask[t])));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a; cs = 1'b1; wn = 1'b0; wd = d;
    tick();
    cs = 1'b0; wn = 1'b1; wd = '0;
  endtask

  task automatic zero_checks(input string tag);
    for (int t = 0; t < 3; t++) begin
      check($sformatf("%s_rd%0d", tag, t), rd_obs[t], 32'h0);
      check($sformatf("%s_irq%0d", tag, t), 32'(irq_obs[t]), 32'h0);
    end
  endtask

  initial begin
    model_reset();
    in_port = 4'hF;
    #3;
    zero_checks("rst");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Lines held high through reset: visible in DATA, never captured
    addr = 2'd0;
    ticks(4);
    check("data_after_rst", rd_obs[0], 32'hF);
    addr = 2'd3;
    ticks(2);
    check("ecap_suppressed", rd_obs[2], 32'h0);
    check("irq_suppressed", 32'(irq_obs[2]), 32'h0);

    in_port = 4'h0;
    ticks(5);
    bus_write(2'd3, 32'hFFFF_FFFF);
    ticks(3);

    // Rising capture
    in_port = 4'b0101;
    ticks(4);
    check("ecap_rise", rd_obs[0], 32'h5);
    in_port = 4'b0000;
    ticks(5);
    check("no_fall_capture", rd_obs[0], 32'h5);
    check("irq_mask0", 32'(irq_obs[0]), 32'h0);

    bus_write(2'd2, 32'h4);
    check("irq_after_mask", 32'(irq_obs[0]), 32'h1);
    bus_write(2'd3, 32'h4);
    check("irq_after_clr", 32'(irq_obs[0]), 32'h0);
    addr = 2'd3;
    tick();
    check("ecap_w1c", rd_obs[0], 32'h1);

    // Clear of bit 0 coincides with the capture of a new rising edge on bit 0
    in_port = 4'b0001;
    ticks(2);
    bus_write(2'd3, 32'h1);
    addr = 2'd3;
    tick();
    check("edge_wins", rd_obs[0], 32'h1);

    // Any-edge: a 5-cycle pulse on bit 3; the falling edge alone re-captures after a clear
    ticks(3);
    bus_write(2'd3, 32'hF);
    addr = 2'd3;
    in_port = 4'b1001;
    ticks(4);
    check("any_rise", 32'(rd_obs[2][3]), 32'h1);
    bus_write(2'd3, 32'h8);
    in_port = 4'b0001;
    addr = 2'd3;
    tick();
    check("any_cleared", 32'(rd_obs[2][3]), 32'h0);
    ticks(3);
    check("any_fall", 32'(rd_obs[2][3]), 32'h1);

    // Reserved address and read-only DATA
    addr = 2'd1;
    tick();
    check("rsvd_zero", rd_obs[0], 32'h0);
    bus_write(2'd0, 32'hFFFF_FFFF);
    addr = 2'd0;
    tick();
    check("data_ro", rd_obs[0], 32'h1);

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      addr = 2'($urandom_range(0, 3));
      cs   = 1'($urandom_range(0, 1));
      wn   = ($urandom_range(0, 3) != 0);
      wd   = $urandom;
      if (i == 200) begin
        reset_n = 1'b0;
        #1;
        zero_checks("mid_rst");
        model_reset();
        #1 reset_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_in_pio.md
Name: sd_in_pio

Overview:
- Avalon-MM slave input port. It is the read-side counterpart of the single-bit SD clock/command output PIOs.
- Samples external SD-side input lines (DAT0..DAT3, card-detect, etc.) into the clk domain through a synchronizer.
- Detects edges on the synchronized lines, latches them in an edge-capture register, and raises a maskable interrupt to the Nios II.
- Software polls the data register or services irq.

Parameters:
- WIDTH, 4, number of input lines (1..32).
- EDGE_TYPE, 0, 0 = rising, 1 = falling, 2 = any edge captured.
- SYNC_STAGES, 2, synchronizer flops per line (2..3).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  read data, registered.
- irq  out  1  interrupt, active high.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low on reset_n, and clears every flop.
- Reset values: sync chain 0, delay reg 0, irqmask 0, edgecapture 0, readdata 0, irq 0, startup counter 0.
- Register map (32-bit, unused bits read 0):
  - addr 0 DATA (RO): synchronized inputs in bits [WIDTH-1:0].
  - addr 1 reserved: reads 0, writes ignored.
  - addr 2 IRQMASK (RW): bits [WIDTH-1:0].
  - addr 3 EDGECAP (R/W1C): bits [WIDTH-1:0].
- Write: a write occurs in a cycle where chipselect=1 and write_n=0; it takes effect at the next posedge. Writes to addr 0 and addr 1 are ignored.
- Read: readdata is registered. Every posedge, readdata <= mux(address) regardless of chipselect. Read latency is 1 clock.
- Synchronizer: in_port passes through SYNC_STAGES flops. sync_out is the last stage and feeds DATA.
- Edge detect: delay reg d <= sync_out every cycle.
  - rise = sync_out & ~d
  - fall = ~sync_out & d
  - edge is selected by EDGE_TYPE (rise, fall, or rise | fall).
- Latency: with SYNC_STAGES=2 and in_port stable before posedge 1, DATA is updated at posedge 2 (readable on readdata after posedge 3). The EDGECAP bit sets at posedge 3.
- Startup suppression:
  - A counter runs 0..SYNC_STAGES+1 after reset release, then saturates.
  - Edge capture is disabled while the counter is not saturated, so lines held high through reset do not produce spurious captures.
  - The counter does not restart without reset.
- EDGECAP update per bit i: ecap[i] <= edge[i] | (ecap[i] & ~(wr3 & writedata[i])).
  - A simultaneous edge and clear leaves the bit set (edge wins).
  - Writing 0 leaves the bit unchanged.
- irq = |(ecap & irqmask), combinational from registers. It has no glitch path from the bus.
- IRQMASK write: irqmask <= writedata[WIDTH-1:0]. irq reflects the new mask in the cycle after the write.
- Reset mid-operation: asserting reset_n low clears all state immediately (asynchronous). After release, startup suppression applies again.
- Widths: writedata bits above WIDTH-1 are ignored. readdata upper bits are 0.

Test Plan:
- Reset with in_port=4'hF held → DATA reads 4'hF after 4 cycles. EDGECAP stays 0 and irq stays 0 (startup suppression).
- EDGE_TYPE=0: in_port 0→4'b0101 → EDGECAP=4'b0101 at posedge 3 after the change; in_port back to 0 → no new capture; irq=0 with mask 0.
- Write IRQMASK=4'b0100 with EDGECAP=4'b0101 → irq=1 one cycle later. Write EDGECAP=4'b0100 → EDGECAP=4'b0001 and irq=0.
- Write-1-clear of bit 0 in the same cycle as a new rising edge on bit 0 → bit 0 remains 1.
- EDGE_TYPE=2: pulse bit 3 high for 5 cycles → EDGECAP[3]=1; clear it → the falling edge alone sets it again.
- Read addr 1, then write addr 0 with 32'hFFFFFFFF → readdata=0 on addr 1; DATA unaffected. Assert reset_n mid-run → all registers 0 asynchronously.
